// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: three-channel PWM drive for the tri-color LED, duties shadowed at period boundaries.
// Define RGB_PWM_FADE_EN to ramp duties one LSB per FADE_DIV periods instead of jumping to target.
module rgb_pwm_fader #(
   parameter int PWM_PRESCALE = 4,
   parameter int FADE_DIV     = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] fft_red,
   input  logic [7:0] fft_green,
   input  logic [7:0] fft_blue,
   input  logic       enable,
   output logic       led_r,
   output logic       led_g,
   output logic       led_b,
   output logic [7:0] duty_r,
   output logic [7:0] duty_g,
   output logic [7:0] duty_b,
   output logic       period_strobe
);
   // state | meaning
   // IDLE  | prescaler/pwm_cnt held at 0, LEDs dark, duties and targets retained
   // RUN   | prescaler and pwm_cnt counting, LEDs driven from duty compare

   if (PWM_PRESCALE < 1 || PWM_PRESCALE > 65535) begin : g_bad_prescale
      $error("rgb_pwm_fader: PWM_PRESCALE out of range 1..65535");
   end
   if (FADE_DIV < 1 || FADE_DIV > 255) begin : g_bad_fade_div
      $error("rgb_pwm_fader: FADE_DIV out of range 1..255");
   end

   localparam logic [15:0] PRE_MAX = 16'(PWM_PRESCALE - 1);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t          state;
   logic [15:0]     pre_cnt;
   logic [7:0]      pwm_cnt;
   logic [2:0]      led;
   logic [2:0][7:0] fft;
   logic [2:0][7:0] target;
   logic [2:0][7:0] target_nxt;
   logic [2:0][7:0] duty;
   logic            run;
   logic            tick;
   logic            strobe;

   assign fft = {fft_blue, fft_green, fft_red};

   // Gating with enable makes a deassertion take effect on this very edge,
   // which also suppresses a strobe that lands on it.
   assign run        = (state == RUN) && enable;
   assign tick       = run && (pre_cnt == PRE_MAX);
   assign strobe     = tick && (pwm_cnt == 8'hFF);
   assign target_nxt = strobe ? fft : target;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         pre_cnt <= '0;
         pwm_cnt <= '0;
         led     <= '0;
      end else begin
         case (state)
            IDLE:    if (enable) state <= RUN;
            RUN:     if (!enable) state <= IDLE;
            default: state <= IDLE;
         endcase
         if (run) begin
            pre_cnt <= tick ? 16'd0 : pre_cnt + 16'd1;
            if (tick) pwm_cnt <= pwm_cnt + 8'd1;
         end else begin
            pre_cnt <= '0;
            pwm_cnt <= '0;
         end
         for (int i = 0; i < 3; i++) begin
            led[i] <= run && (pwm_cnt < duty[i]);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         target <= '0;
      end else begin
         target <= target_nxt;
      end
   end

`ifdef RGB_PWM_FADE_EN
   localparam logic [7:0] FADE_MAX = 8'(FADE_DIV - 1);

   logic [7:0] fade_cnt;
   logic       fade_step;

   assign fade_step = strobe && (fade_cnt == FADE_MAX);

   function automatic logic [7:0] approach(input logic [7:0] cur, input logic [7:0] goal);
      return (cur < goal) ? cur + 8'd1 : ((cur > goal) ? cur - 8'd1 : cur);
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fade_cnt <= '0;
         duty     <= '0;
      end else begin
         if (strobe) fade_cnt <= fade_step ? 8'd0 : fade_cnt + 8'd1;
         if (fade_step) begin
            for (int i = 0; i < 3; i++) begin
               duty[i] <= approach(duty[i], target_nxt[i]);
            end
         end
      end
   end
`else
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         duty <= '0;
      end else if (strobe) begin
         duty <= target_nxt;
      end
   end
`endif

   assign led_r         = led[0];
   assign led_g         = led[1];
   assign led_b         = led[2];
   assign duty_r        = duty[0];
   assign duty_g        = duty[1];
   assign duty_b        = duty[2];
   assign period_strobe = strobe;

endmodule

// File: doc/rgb_pwm_fader.md
RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 SHALL have parameter PWM_PRESCALE, default 4; clocks per PWM counter tick; legal range 1..65535.
REQ-002 SHALL have parameter FADE_DIV, default 8; PWM periods per fade step; legal range 1..255.
REQ-003 SHALL have port clk, input, 1; the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1; asynchronous, active-low reset.
REQ-005 SHALL have port fft_red, input, 8; red target duty from the KCPSM6 interface register.
REQ-006 SHALL have port fft_green, input, 8; green target duty.
REQ-007 SHALL have port fft_blue, input, 8; blue target duty.
REQ-008 SHALL have port enable, input, 1; 1 runs the PWM, 0 blanks the LEDs and holds the counters.
REQ-009 SHALL have ports led_r, led_g, led_b, output, 1 each; registered PWM drive for the Nexys4 tri-color LED.
REQ-010 SHALL have ports duty_r, duty_g, duty_b, output, 8 each; currently applied duty, for status readback.
REQ-011 SHALL have port period_strobe, output, 1; one-clk pulse at each PWM period boundary.

Function
REQ-012 SHALL contain a prescaler that counts 0..PWM_PRESCALE-1 and asserts an internal tick while at PWM_PRESCALE-1, then wraps to 0.
REQ-013 SHALL advance an 8-bit pwm_cnt by 1 on each tick; pwm_cnt wraps 255->0; one PWM period is 256*PWM_PRESCALE clocks.
REQ-014 SHALL assert period_strobe for exactly one clk on the cycle where tick=1 and pwm_cnt=255.
REQ-015 SHALL sample fft_red, fft_green and fft_blue into shadow target registers only on the period_strobe cycle; mid-period input changes SHALL NOT affect the current period.
REQ-016 SHALL drive led_x <= (state==RUN) && (pwm_cnt < duty_x), registered, for one clk of latency.
REQ-017 SHALL keep led_x permanently low when duty=0, and SHALL give 255/256 on-time when duty=255.
REQ-018 SHALL implement a two-state FSM. IDLE -> RUN when enable=1. RUN -> IDLE when enable=0.
REQ-019 SHALL, in IDLE, hold the prescaler and pwm_cnt at 0, force led_r/g/b and period_strobe low, and retain duty_x and the targets.
REQ-020 SHALL, when enable deasserts mid-period, drive the LEDs low on the next clk; on re-enable, counting restarts at pwm_cnt=0.
REQ-021 SHALL update duty_x only on the period_strobe cycle. The new duty takes effect from pwm_cnt=0 of the next period, so no partial-period glitch occurs.
REQ-022 SHALL treat a period_strobe that coincides with an enable deassertion as not occurring.

Reset
REQ-023 SHALL, while reset=0, asynchronously clear the prescaler, pwm_cnt, fade counter, targets, duty_x, led_x and period_strobe to 0, and force state to IDLE.
REQ-024 SHALL leave reset synchronously on the first clk edge after reset rises; an assertion mid-period SHALL abort the period immediately.

Configuration
REQ-025 SHALL use macro RGB_PWM_FADE_EN to compile the fade feature in or out.
REQ-026 SHALL, with RGB_PWM_FADE_EN defined, count period_strobes in a fade counter (0..FADE_DIV-1). On each wrap, every duty_x moves one LSB toward its target; a duty equal to its target holds; duty never overshoots and never wraps.
REQ-027 SHALL, with RGB_PWM_FADE_EN undefined, load duty_x <= target on every period_strobe and omit the fade counter.

Verification (PWM_PRESCALE=1, FADE_DIV=2 unless noted)
REQ-028 SHALL cover: reset=0 mid-run -> all outputs 0 within the same cycle, state IDLE, duty_r/g/b=0.
REQ-029 SHALL cover: fade undefined, enable=1, fft_red=0x40 -> after the first period_strobe, led_r high for exactly 64 of every 256 clks; period_strobe every 256 clks.
REQ-030 SHALL cover: fade undefined, fft_green=0x00 and fft_blue=0xFF -> led_g never high; led_b low exactly 1 clk per period.
REQ-031 SHALL cover: fade defined, duty_r=0x10, fft_red=0x13 -> duty_r steps 0x11, 0x12, 0x13 every 2 period_strobes, then holds at 0x13.
REQ-032 SHALL cover: fft_red changed 0x20->0x80 at pwm_cnt=100 -> duty_r stays 0x20 through that period and changes only at the next period_strobe.
REQ-033 SHALL cover: enable dropped at pwm_cnt=50 and reasserted 10 clks later -> LEDs low the next clk, pwm_cnt restarts at 0, duty values retained.
